// File: rtl/pwm_dac_modulator.sv
// ---------------------------------------------------------------------------
// pwm_dac_modulator
//
// Purpose:
//   Turns a paced stream of unsigned samples into a PWM waveform. Each
//   accepted sample sets the duty of exactly one PWM period of 2^DATA_W ticks.
//   The pin drives an external RC low-pass filter, which makes this the
//   analogue output stage.
//   Samples are double-buffered. A pending slot takes the next sample through
//   a valid/ready handshake while the active duty plays out. A period that
//   starts with an empty pending slot repeats the last duty and reports an
//   underrun.
//
// Ports:
//   clk            system clock; every register updates on its rising edge
//   reset          synchronous, active-high; clears all state
//   enable         1 = modulate, 0 = idle with the pin held low
//   sample_in      unsigned duty sample (DATA_W bits)
//   sample_valid   sample_in is valid this cycle
//   sample_ready   pending slot is empty (low while reset is asserted)
//   pwm_out        registered PWM pin
//   period_start   one-cycle pulse when the tick counter restarts at 0
//   underrun       one-cycle pulse when a period starts without a new sample
//   underrun_count saturating count of underrun pulses (UCNT_W bits)
// ---------------------------------------------------------------------------
module pwm_dac_modulator #(
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 1,
    parameter int UCNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              pwm_out,
    output logic              period_start,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_count
);

    // The prescaler needs at least one bit, even when PRESCALE == 1.
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] duty_active;
    logic [DATA_W-1:0] pend;
    logic              pend_valid;
    logic [PRE_W-1:0]  pre;

    logic tick;
    logic cnt_last;
    logic accept;

    // Saturating increment for the underrun counter: it holds at all-ones.
    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (&v) ? v : v + UCNT_W'(1);
    endfunction

    // Ready depends only on the pending slot. A sample that arrives in the
    // cycle a period boundary consumes the slot must wait one cycle; it is
    // never passed straight through to the active duty.
    assign sample_ready = ~pend_valid & ~reset;
    assign accept       = sample_valid & sample_ready;
    assign tick         = (pre == PRE_LAST);
    assign cnt_last     = &cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            pre            <= '0;
            duty_active    <= '0;
            pend           <= '0;
            pend_valid     <= 1'b0;
            pwm_out        <= 1'b0;
            period_start   <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            period_start <= 1'b0;
            underrun     <= 1'b0;

            // Accepting a sample needs an empty slot, and consuming one needs
            // a full slot. The two therefore never both write pend_valid in
            // the same cycle.
            if (accept) begin
                pend       <= sample_in;
                pend_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    pre     <= '0;
                    pwm_out <= 1'b0;
                    if (enable) begin
                        state        <= RUN;
                        period_start <= 1'b1;
                        if (pend_valid) begin
                            duty_active <= pend;
                            pend_valid  <= 1'b0;
                        end else begin
                            // Nothing has been played yet, so a starved
                            // start runs a silent (duty 0) period.
                            duty_active    <= '0;
                            underrun       <= 1'b1;
                            underrun_count <= sat_inc(underrun_count);
                        end
                    end
                end

                RUN: begin
                    if (!enable) begin
                        // The pending sample is kept for the next RUN entry.
                        state   <= IDLE;
                        cnt     <= '0;
                        pre     <= '0;
                        pwm_out <= 1'b0;
                    end else begin
                        // The pin lags cnt/duty_active by one clock. That
                        // gives exactly duty_active high clocks per period.
                        pwm_out <= (cnt < duty_active);
                        if (tick) begin
                            pre <= '0;
                            cnt <= cnt + DATA_W'(1);
                            if (cnt_last) begin
                                period_start <= 1'b1;
                                if (pend_valid) begin
                                    duty_active <= pend;
                                    pend_valid  <= 1'b0;
                                end else begin
                                    // Starved: repeat the last duty.
                                    underrun       <= 1'b1;
                                    underrun_count <= sat_inc(underrun_count);
                                end
                            end
                        end else begin
                            pre <= pre + PRE_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_dac_modulator.sv
// ---------------------------------------------------------------------------
// tb_pwm_dac_modulator
//
// Directed bench for pwm_dac_modulator. Two instances share every input:
//   dut  : PRESCALE = 1, period 256 clocks
//   dut3 : PRESCALE = 3, period 768 clocks
// Inputs change 1 time unit after a rising edge. Outputs are read at that
// same point, so each read shows what the edge just registered.
// ---------------------------------------------------------------------------
module tb_pwm_dac_modulator;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;

    logic        sample_ready;
    logic        pwm_out;
    logic        period_start;
    logic        underrun;
    logic [15:0] underrun_count;

    logic        sample_ready3;
    logic        pwm_out3;
    logic        period_start3;
    logic        underrun3;
    logic [15:0] underrun_count3;

    int n_cmp;
    int n_err;

    pwm_dac_modulator #(.DATA_W(8), .PRESCALE(1), .UCNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    pwm_dac_modulator #(.DATA_W(8), .PRESCALE(3), .UCNT_W(16)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready3),
        .pwm_out        (pwm_out3),
        .period_start   (period_start3),
        .underrun       (underrun3),
        .underrun_count (underrun_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one 256-clock period window of dut. The window starts just after
    // an entry or boundary edge and ends on the next boundary edge.
    // A sample (s) is offered before the first edge when send=1. When hold=1,
    // valid stays high afterwards and the data switches to s2. Otherwise
    // valid drops after the first edge.
    task automatic run_period(input bit send, input logic [7:0] s,
                              input bit hold, input logic [7:0] s2,
                              output int highs, output int starts,
                              output int unders, output int readys,
                              output bit first_hi, output bit last_start,
                              output bit last_under);
        highs = 0; starts = 0; unders = 0; readys = 0;
        first_hi = 1'b0; last_start = 1'b0; last_under = 1'b0;
        sample_valid = send;
        sample_in    = s;
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 1) begin
                if (hold) sample_in = s2;
                else      sample_valid = 1'b0;
                first_hi = pwm_out;
            end
            if (pwm_out)      highs++;
            if (period_start) starts++;
            if (underrun)     unders++;
            if (sample_ready) readys++;
            if (k == 256) begin
                last_start = period_start;
                last_under = underrun;
            end
        end
    endtask

    initial begin
        int  highs, starts, unders, readys;
        bit  first_hi, last_start, last_under;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        enable = 1'b0;
        sample_in = 8'd0;
        sample_valid = 1'b0;

        // ---- power-on reset ----
        repeat (3) step();
        check_bit("por_pwm", pwm_out, 1'b0);
        check_bit("por_ready", sample_ready, 1'b0);
        check_int("por_ucnt", int'(underrun_count), 0);
        check_bit("por_pstart", period_start, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("por_ready_after", sample_ready, 1'b1);

        // ---- preload 128 and enable ----
        sample_in = 8'd128; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        check_bit("preload_ready_low", sample_ready, 1'b0);
        enable = 1'b1;
        step();
        check_bit("entry_pstart", period_start, 1'b1);
        check_bit("entry_underrun", underrun, 1'b0);
        check_bit("entry_pwm", pwm_out, 1'b0);

        // P0: duty 128; offer 0 for the next period
        run_period(1'b1, 8'd0, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p0_highs", highs, 128);
        check_bit("p0_first_high", first_hi, 1'b1);
        check_int("p0_starts", starts, 1);
        check_bit("p0_start_at_end", last_start, 1'b1);
        check_int("p0_unders", unders, 0);

        // P1: duty 0; offer 255
        run_period(1'b1, 8'd255, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p1_highs_duty0", highs, 0);
        check_int("p1_unders", unders, 0);

        // P2: duty 255; offer 200
        run_period(1'b1, 8'd200, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p2_highs_duty255", highs, 255);
        check_int("p2_starts", starts, 1);

        // P3: duty 200; nothing offered, so the boundary starves
        run_period(1'b0, 8'd0, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p3_highs", highs, 200);
        check_bit("p3_underrun_at_end", last_under, 1'b1);
        check_int("p3_unders", unders, 1);
        check_int("p3_ucnt", int'(underrun_count), 1);

        // P4: duty 200 repeated; starves again
        run_period(1'b0, 8'd0, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p4_repeat_highs", highs, 200);
        check_bit("p4_underrun_at_end", last_under, 1'b1);
        check_int("p4_ucnt", int'(underrun_count), 2);

        // P5: valid held with 10 then 20; only 10 enters the pending slot
        run_period(1'b1, 8'd10, 1'b1, 8'd20, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p5_highs", highs, 200);
        check_int("p5_ready_cycles", readys, 1);
        check_bit("p5_ready_after_boundary", sample_ready, 1'b1);
        check_int("p5_unders", unders, 0);

        // P6: 20 (still valid) is accepted on the first edge after the boundary
        run_period(1'b1, 8'd20, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p6_highs_10", highs, 10);
        check_int("p6_ready_cycles", readys, 1);

        // P7: duty 20; offer 250
        run_period(1'b1, 8'd250, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("p7_highs_20", highs, 20);
        check_int("p7_ucnt", int'(underrun_count), 2);

        // ---- P8: disable at cnt = 50 ----
        repeat (50) step();
        check_bit("pre_disable_pwm", pwm_out, 1'b1);
        enable = 1'b0;
        step();
        check_bit("disable_pwm_low", pwm_out, 1'b0);
        check_bit("disable_no_pstart", period_start, 1'b0);
        repeat (5) step();
        check_bit("idle_pwm_low", pwm_out, 1'b0);

        // preload 64 while idle, then re-enable
        sample_in = 8'd64; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        enable = 1'b1;
        step();
        check_bit("reenable_pstart", period_start, 1'b1);
        check_bit("reenable_underrun", underrun, 1'b0);
        run_period(1'b0, 8'd0, 1'b0, 8'd0, highs, starts, unders, readys, first_hi, last_start, last_under);
        check_int("reenable_highs", highs, 64);
        check_bit("reenable_full_period", last_start, 1'b1);
        check_int("reenable_starts", starts, 1);
        check_int("reenable_ucnt", int'(underrun_count), 3);

        // ---- reset held 3 clocks mid-RUN with a sample pending ----
        sample_in = 8'd77; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        repeat (9) step();
        check_bit("midrun_pwm_high", pwm_out, 1'b1);
        reset = 1'b1;
        enable = 1'b0;
        step();
        check_bit("rst_pwm", pwm_out, 1'b0);
        check_bit("rst_ready", sample_ready, 1'b0);
        check_int("rst_ucnt", int'(underrun_count), 0);
        step();
        step();
        check_bit("rst3_ready", sample_ready, 1'b0);
        check_bit("rst3_pwm", pwm_out, 1'b0);
        reset = 1'b0;
        #1;
        check_bit("post_rst_ready", sample_ready, 1'b1);
        enable = 1'b1;
        step();
        check_bit("post_rst_pstart", period_start, 1'b1);
        check_bit("post_rst_underrun", underrun, 1'b1);
        check_int("post_rst_ucnt", int'(underrun_count), 1);
        highs = 0;
        repeat (20) begin
            step();
            if (pwm_out) highs++;
        end
        check_int("post_rst_silent", highs, 0);

        // ---- PRESCALE = 3 instance: preload 128 ----
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        sample_in = 8'd128; sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        enable = 1'b1;
        step();
        check_bit("ps3_entry_pstart", period_start3, 1'b1);
        check_bit("ps3_entry_underrun", underrun3, 1'b0);
        highs = 0; starts = 0;
        first_hi = 1'b0; last_start = 1'b0;
        for (int k = 1; k <= 768; k++) begin
            step();
            if (k == 1)   first_hi = pwm_out3;
            if (k == 768) last_start = period_start3;
            if (pwm_out3)      highs++;
            if (period_start3) starts++;
        end
        check_bit("ps3_first_high", first_hi, 1'b1);
        check_int("ps3_highs", highs, 384);
        check_int("ps3_starts", starts, 1);
        check_bit("ps3_start_at_768", last_start, 1'b1);
        check_bit("ps3_ready", sample_ready3, 1'b1);
        check_int("ps3_ucnt", int'(underrun_count3), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
